// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: default RAM width,
// requester port indices and the bundled request record.
package dmem_pkg;

    localparam int ADDR_W_DEF = 9;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DMA = 1'b1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/rr_grant2.sv
// Two-way grant selection. A lone requester always wins. On a tie, round-robin
// mode hands the grant to whichever port did not win last; fixed mode favours
// the CPU port unless the starvation guard forces the DMA port in.
module rr_grant2
    import dmem_pkg::*;
(
    input  logic [1:0] req_i,
    input  logic       last_gnt_i,
    input  logic       force_p1_i,
    input  logic       mode_i,
    output logic [1:0] gnt_o
);

    // Pick at most one winner from the current requests
    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01: gnt_o = 2'b01;
            2'b10: gnt_o = 2'b10;
            2'b11: begin
                if (mode_i) begin
                    gnt_o = (last_gnt_i == PORT_DMA) ? 2'b01 : 2'b10;
                end else begin
                    gnt_o = force_p1_i ? 2'b10 : 2'b01;
                end
            end
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data RAM between the CPU data port (port 0) and the
// DMA/loader port (port 1). Grants are combinational in the acceptance cycle;
// read data returns on the requesting port one cycle later. Accesses outside
// the RAM are still accepted but never write, and raise a one-cycle err pulse.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RR_MODE  = 0,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [31:0]       p0_addr,
    input  logic [31:0]       p0_wdata,
    output logic              p0_gnt,
    output logic              p0_rvalid,
    output logic [31:0]       p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [31:0]       p1_addr,
    input  logic [31:0]       p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [31:0]       p1_rdata,
    output logic              err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);

    localparam int              CNT_W    = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);
    localparam logic            MODE_RR  = (RR_MODE != 0);

    logic             last_gnt_q, last_gnt_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rd_pend_q, rd_pend_d;
    logic             rd_port_q, rd_port_d;
    logic             err_q, err_d;

    logic [1:0] arb_gnt;
    logic [1:0] gnt;
    logic       any_gnt;
    logic       sel_port;
    logic       out_of_range;
    mem_req_t   req0, req1, sel_req;

    assign req0 = '{we: p0_we, addr: p0_addr, wdata: p0_wdata};
    assign req1 = '{we: p1_we, addr: p1_addr, wdata: p1_wdata};

    rr_grant2 u_grant (
        .req_i      ({p1_req, p0_req}),
        .last_gnt_i (last_gnt_q),
        .force_p1_i (wait_cnt_q == WAIT_MAX),
        .mode_i     (MODE_RR),
        .gnt_o      (arb_gnt)
    );

    // No grant may escape while reset is held, even with requests pending
    assign gnt          = arb_gnt & {2{~rst}};
    assign p0_gnt       = gnt[0];
    assign p1_gnt       = gnt[1];
    assign any_gnt      = |gnt;
    assign sel_port     = gnt[1] ? PORT_DMA : PORT_CPU;
    assign sel_req      = gnt[1] ? req1 : req0;
    assign out_of_range = any_gnt && (sel_req.addr[31:ADDR_W] != '0);

    // Steer the winning request onto the RAM pins; idle cycles drive zeros
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        if (any_gnt) begin
            mem_we   = sel_req.we & ~out_of_range;
            mem_addr = sel_req.addr[ADDR_W-1:0];
            mem_din  = sel_req.wdata;
        end
    end

    // Next-state for fairness history, starvation counter and response tracking
    always_comb begin
        last_gnt_d = last_gnt_q;
        if (any_gnt) begin
            last_gnt_d = sel_port;
        end
        wait_cnt_d = wait_cnt_q;
        if (!p1_req || gnt[1]) begin
            wait_cnt_d = '0;
        end else if (gnt[0] && (wait_cnt_q != WAIT_MAX)) begin
            wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
        rd_pend_d = any_gnt & ~sel_req.we;
        rd_port_d = sel_port;
        err_d     = out_of_range;
    end

    // State registers; reset also drops any read still in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_gnt_q <= PORT_CPU;
            wait_cnt_q <= '0;
            rd_pend_q  <= 1'b0;
            rd_port_q  <= PORT_CPU;
            err_q      <= 1'b0;
        end else begin
            last_gnt_q <= last_gnt_d;
            wait_cnt_q <= wait_cnt_d;
            rd_pend_q  <= rd_pend_d;
            rd_port_q  <= rd_port_d;
            err_q      <= err_d;
        end
    end

    // An out-of-range read still completes the handshake but returns zero
    assign p0_rvalid = rd_pend_q && (rd_port_q == PORT_CPU);
    assign p1_rvalid = rd_pend_q && (rd_port_q == PORT_DMA);
    assign p0_rdata  = (p0_rvalid && !err_q) ? mem_dout : '0;
    assign p1_rdata  = (p1_rvalid && !err_q) ? mem_dout : '0;
    assign err       = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter. Two instances share one clock and reset: instance 0
// runs fixed priority with the starvation guard, instance 1 runs round-robin.
// Each has its own RAM, requesters and reference model; read/err responses
// are queued when a grant is predicted and matched by a separate monitor.
module tb_dmem_arbiter;

    localparam int MAXW = 4;
    localparam int RAMW = 512;

    typedef struct {
        int          due;
        bit          port;
        bit          rd;
        bit          err;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clearRam = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        p0Req[2], p0We[2], p1Req[2], p1We[2];
    logic [31:0] p0Addr[2], p0Wd[2], p1Addr[2], p1Wd[2];
    logic        p0Gnt[2], p0Rv[2], p1Gnt[2], p1Rv[2], errO[2], memWe[2];
    logic [31:0] p0Rd[2], p1Rd[2], memDin[2];
    logic [8:0]  memAddr[2];

    // Requester slots [dut][port]: a request stays posted until granted
    bit          slotAct[2][2];
    bit          slotWe[2][2];
    logic [31:0] slotAddr[2][2];
    logic [31:0] slotWdata[2][2];

    // Reference model state
    int          lastPort[2];
    int          streak[2];
    logic [31:0] refMem[2][RAMW];
    rsp_t        rspQ[2][$];

    always #5 clk = ~clk;

    // Cycle index used to time-stamp expected responses
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 2; g++) begin : gDut
        logic [31:0] ram [RAMW];
        logic [31:0] dout;

        // Synchronous single-port RAM with one-cycle registered read
        always @(posedge clk) begin
            if (clearRam) begin
                for (int i = 0; i < RAMW; i++) ram[i] <= '0;
            end else if (memWe[g]) begin
                ram[memAddr[g]] <= memDin[g];
            end
            dout <= ram[memAddr[g]];
        end

        dmem_arbiter #(.ADDR_W(9), .RR_MODE(g), .MAX_WAIT(MAXW)) dut (
            .clk(clk), .rst(rst),
            .p0_req(p0Req[g]), .p0_we(p0We[g]), .p0_addr(p0Addr[g]), .p0_wdata(p0Wd[g]),
            .p0_gnt(p0Gnt[g]), .p0_rvalid(p0Rv[g]), .p0_rdata(p0Rd[g]),
            .p1_req(p1Req[g]), .p1_we(p1We[g]), .p1_addr(p1Addr[g]), .p1_wdata(p1Wd[g]),
            .p1_gnt(p1Gnt[g]), .p1_rvalid(p1Rv[g]), .p1_rdata(p1Rd[g]),
            .err(errO[g]), .mem_we(memWe[g]), .mem_addr(memAddr[g]), .mem_din(memDin[g]),
            .mem_dout(dout)
        );
    end

    task automatic checkOutput(input string name, input int m, input logic [127:0] act,
                               input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s dut%0d cyc%0d: got %0h expected %0h", name, m, cyc, act, exp);
        end
    endtask

    // Monitor: compare response outputs against whatever is due this cycle
    always @(negedge clk) begin
        for (int m = 0; m < 2; m++) begin
            rsp_t        r;
            logic        eV0, eV1, eErr;
            logic [31:0] eD0, eD1;
            eV0 = 0; eV1 = 0; eErr = 0; eD0 = '0; eD1 = '0;
            while (rspQ[m].size() > 0 && rspQ[m][0].due < cyc) begin
                r = rspQ[m].pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL resp_missed dut%0d: due %0d still pending at %0d", m, r.due, cyc);
            end
            if (rspQ[m].size() > 0 && rspQ[m][0].due == cyc) begin
                r    = rspQ[m].pop_front();
                eV0  = r.rd && !r.port;
                eV1  = r.rd && r.port;
                eErr = r.err;
                if (eV0) eD0 = r.data;
                if (eV1) eD1 = r.data;
            end
            checkOutput("resp", m, {p0Rv[m], p1Rv[m], errO[m], p0Rd[m], p1Rd[m]},
                        {eV0, eV1, eErr, eD0, eD1});
        end
    end

    task automatic resetModel();
        for (int m = 0; m < 2; m++) begin
            lastPort[m] = 0;
            streak[m]   = 0;
            rspQ[m].delete();
        end
    endtask

    function automatic int expGrant(int m);
        bit r0, r1;
        r0 = slotAct[m][0];
        r1 = slotAct[m][1];
        if (rst || (!r0 && !r1)) return -1;
        if (r0 && !r1) return 0;
        if (r1 && !r0) return 1;
        if (m == 1) return (lastPort[m] == 0) ? 1 : 0;
        return (streak[m] >= MAXW) ? 1 : 0;
    endfunction

    // Predict this cycle's grant for one instance, compare, and advance the model
    task automatic evalDut(input int m);
        int          g;
        bit          r1, we, oor;
        logic [31:0] a;
        logic [1:0]  eg;
        logic [41:0] eMem;
        rsp_t        r;
        g    = expGrant(m);
        r1   = slotAct[m][1];
        eg   = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        eMem = '0;
        checkOutput("gnt", m, {p1Gnt[m], p0Gnt[m]}, eg);
        if (g >= 0) begin
            we   = slotWe[m][g];
            a    = slotAddr[m][g];
            oor  = (a >= RAMW);
            eMem = {we && !oor, 9'(a % RAMW), slotWdata[m][g]};
            if (!we || oor) begin
                r.due  = cyc + 1;
                r.port = (g == 1);
                r.rd   = !we;
                r.err  = oor;
                r.data = (!we && !oor) ? refMem[m][a % RAMW] : 32'h0;
                rspQ[m].push_back(r);
            end
            if (we && !oor) refMem[m][a % RAMW] = slotWdata[m][g];
            slotAct[m][g] = 0;
            lastPort[m]   = g;
        end
        checkOutput("mem", m, {memWe[m], memAddr[m], memDin[m]}, eMem);
        if (!r1 || g == 1) streak[m] = 0;
        else if (g == 0 && streak[m] < MAXW) streak[m]++;
    endtask

    // One clock cycle: apply reset level and posted requests, then check grants
    task automatic applyStimulus(input bit rstVal);
        @(negedge clk);
        #1;
        rst = rstVal;
        if (rstVal) resetModel();
        for (int m = 0; m < 2; m++) begin
            p0Req[m] = slotAct[m][0]; p0We[m] = slotWe[m][0];
            p0Addr[m] = slotAddr[m][0]; p0Wd[m] = slotWdata[m][0];
            p1Req[m] = slotAct[m][1]; p1We[m] = slotWe[m][1];
            p1Addr[m] = slotAddr[m][1]; p1Wd[m] = slotWdata[m][1];
        end
        #1;
        for (int m = 0; m < 2; m++) evalDut(m);
    endtask

    task automatic postBoth(input int port, input bit we, input logic [31:0] addr,
                            input logic [31:0] wdata);
        for (int m = 0; m < 2; m++) begin
            slotAct[m][port]   = 1;
            slotWe[m][port]    = we;
            slotAddr[m][port]  = addr;
            slotWdata[m][port] = wdata;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0);
    endtask

    initial begin
        int p1Cnt[2];
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < RAMW; i++) refMem[m][i] = '0;
            for (int p = 0; p < 2; p++) begin
                slotAct[m][p] = 0; slotWe[m][p] = 0; slotAddr[m][p] = '0; slotWdata[m][p] = '0;
            end
        end
        resetModel();

        // Reset with a request already posted: nothing may be granted
        postBoth(1, 0, 32'h4, 32'h0);
        for (int i = 0; i < 3; i++) applyStimulus(1);
        clearRam = 1'b0;
        idle(3);

        // CPU-only write then read-back
        postBoth(0, 1, 32'h10, 32'hDEADBEEF);
        applyStimulus(0);
        postBoth(0, 0, 32'h10, 32'h0);
        idle(3);

        // Both ports reading continuously from a fresh reset
        applyStimulus(1);
        p1Cnt[0] = 0; p1Cnt[1] = 0;
        for (int i = 0; i < 20; i++) begin
            for (int m = 0; m < 2; m++) begin
                if (!slotAct[m][0]) begin
                    slotAct[m][0] = 1; slotWe[m][0] = 0; slotAddr[m][0] = 32'h24;
                end
                if (!slotAct[m][1]) begin
                    slotAct[m][1] = 1; slotWe[m][1] = 0; slotAddr[m][1] = 32'h20;
                end
            end
            applyStimulus(0);
            for (int m = 0; m < 2; m++) p1Cnt[m] += int'(p1Gnt[m]);
        end
        checkOutput("p1_share", 0, p1Cnt[0], 4);
        checkOutput("p1_share", 1, p1Cnt[1], 10);
        idle(4);

        // Out-of-range write must not alias onto address 0
        postBoth(1, 1, 32'h0, 32'hCAFE0000);
        applyStimulus(0);
        postBoth(1, 1, 32'h200, 32'h12345678);
        applyStimulus(0);
        postBoth(1, 0, 32'h0, 32'h0);
        applyStimulus(0);
        postBoth(0, 0, 32'h8000_0010, 32'h0);
        idle(3);

        // Read response and next grant in the same cycle
        postBoth(0, 0, 32'h10, 32'h0);
        applyStimulus(0);
        postBoth(1, 1, 32'h30, 32'hA5A55A5A);
        applyStimulus(0);
        postBoth(0, 0, 32'h30, 32'h0);
        idle(3);

        // Reset lands while a CPU read is in flight
        postBoth(0, 0, 32'h10, 32'h0);
        applyStimulus(0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        resetModel();
        postBoth(1, 0, 32'h10, 32'h0);
        applyStimulus(1);
        applyStimulus(1);
        idle(3);

        // Randomized traffic on both instances
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < 2; m++) begin
                for (int p = 0; p < 2; p++) begin
                    if (!slotAct[m][p] && ($urandom_range(0, 1) == 1)) begin
                        slotAct[m][p]   = 1;
                        slotWe[m][p]    = $urandom_range(0, 1);
                        slotWdata[m][p] = $urandom;
                        if ($urandom_range(0, 7) == 0)
                            slotAddr[m][p] = ($urandom_range(1, 1000) << 9) | $urandom_range(0, 511);
                        else
                            slotAddr[m][p] = $urandom_range(0, 15) * 4;
                    end
                end
            end
            applyStimulus(0);
        end
        idle(6);
        for (int m = 0; m < 2; m++) checkOutput("drain", m, rspQ[m].size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
